load_store_unit: RTL and testbench

Data-memory access stage between the core's execute logic and the four 8-bit byte-lane data-memory banks (lane 0 = bits 7:0 … lane 3 = bits 31:24, little-endian). It accepts one load or store request at a time, drives the bank address, per-lane write strobes and lane-aligned write data, and returns sign/zero-extended load data plus the destination register for the register-file write port. The banks have synchronous 1-cycle read latency; this block sequences around it with a small FSM.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_lane_align.sv | 60 ++++++
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
//   - access size encodings carried on req_size
//   - FSM state encoding (also exported on the debug state port)
//   - per-lane write strobe constants (lane 0 = bits 7:0 ... lane 3 = bits 31:24)
//   - misalignment predicate used when LSU_MISALIGN_EXC_EN is defined
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_e;

  localparam logic [3:0] STRB_NONE    = 4'b0000;
  localparam logic [3:0] STRB_BYTE0   = 4'b0001;
  localparam logic [3:0] STRB_HALF_LO = 4'b0011;
  localparam logic [3:0] STRB_HALF_HI = 4'b1100;
  localparam logic [3:0] STRB_WORD    = 4'b1111;

  // True for a request that cannot be served by one naturally aligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_BAD:  bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational lane steering for the load/store unit.
// Store side: replicates right-justified store data across the byte lanes and
//   builds the per-lane write strobe from size and the low address bits.
// Load side: picks the addressed byte/half out of the bank word and sign- or
//   zero-extends it; word loads pass through.
// Ports:
//   st_size, st_addr_lo, st_wdata -> st_lanes, st_strb   (store steering)
//   ld_size, ld_addr_lo, ld_signed, ld_word -> ld_data   (load extraction)
// Sizes/offsets arrive already normalised (alignment forced, size 11 folded).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_lanes,
  output logic [3:0]  st_strb,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_signed,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_lanes = st_wdata;
    st_strb  = STRB_WORD;
    case (st_size)
      SZ_BYTE: begin
        st_lanes = {4{st_wdata[7:0]}};
        st_strb  = STRB_BYTE0 << st_addr_lo;
      end
      SZ_HALF: begin
        st_lanes = {2{st_wdata[15:0]}};
        st_strb  = st_addr_lo[1] ? STRB_HALF_HI : STRB_HALF_LO;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = ld_word;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage in front of four 8-bit byte-lane
// banks with 1-cycle synchronous read latency. One request in flight at a time.
// Optional feature macro: LSU_MISALIGN_EXC_EN (misaligned / size-11 requests
// complete with rsp_err=1 and no bank access). Without it, misaligned low
// address bits are forced to alignment and size 11 behaves as a word.
// Ports:
//   clk, nrst                      clock, async active-low reset
//   req_valid/req_ready + req_*    request channel
//   mem_addr, mem_wr, mem_wdata    bank word address, lane strobes, lane data
//   mem_rdata                      bank read data (valid the cycle after address)
//   rsp_valid, rsp_rdata, rsp_rd, rsp_err   one-cycle completion, never stalled
//   dbg_state                      current FSM state (lsu_state_e encoding)
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready
// are both high; req_ready is high only in IDLE (and out of reset), so a
// requester may hold req_valid and wait. rsp_valid is a single-cycle pulse
// with no back-pressure.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [4:0]        rsp_rd,
  output logic              rsp_err,
  output logic [2:0]        dbg_state
);

  lsu_state_e state, state_nxt;

  logic              accept;
  logic [1:0]        n_size;
  logic [1:0]        n_lo;
  logic              n_err;
  logic [31:0]       st_lanes;
  logic [3:0]        st_strb;
  logic [31:0]       ld_data;

  logic              we_q;
  logic [1:0]        size_q;
  logic [1:0]        lo_q;
  logic              sgn_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        strb_q;
  logic [31:0]       rdata_q;

  // Upper byte-address bits beyond the bank depth are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign req_ready = nrst & (state == ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign dbg_state = state;

  // Normalise the request before steering so store strobes and the latched
  // load offset always describe an aligned access.
  always_comb begin
    n_size = req_size;
    n_lo   = req_addr[1:0];
`ifdef LSU_MISALIGN_EXC_EN
    n_err  = is_misaligned(req_size, req_addr[1:0]);
`else
    n_err  = 1'b0;
    if (req_size == SZ_BAD) n_size = SZ_WORD;
`endif
    if (n_size == SZ_WORD) n_lo = 2'b00;
    if (n_size == SZ_HALF) n_lo[0] = 1'b0;
  end

  lsu_lane_align u_align (
    .st_size    (n_size),
    .st_addr_lo (n_lo),
    .st_wdata   (req_wdata),
    .st_lanes   (st_lanes),
    .st_strb    (st_strb),
    .ld_size    (size_q),
    .ld_addr_lo (lo_q),
    .ld_signed  (sgn_q),
    .ld_word    (mem_rdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      lo_q        <= 2'b00;
      sgn_q       <= 1'b0;
      rd_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      strb_q      <= STRB_NONE;
      rdata_q     <= '0;
    end else begin
      if (accept) begin
        we_q        <= req_we;
        size_q      <= n_size;
        lo_q        <= n_lo;
        sgn_q       <= req_signed;
        rd_q        <= req_rd;
        mem_addr_q  <= req_addr[ADDR_W+1:2];
        mem_wdata_q <= st_lanes;
        strb_q      <= st_strb;
        rdata_q     <= '0;
      end else if (state == ST_RD2) begin
        // Bank sampled the address at the end of RD1; its data is valid now.
        rdata_q <= ld_data;
      end
    end
  end

`ifdef LSU_MISALIGN_EXC_EN
  logic err_q;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= n_err;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    mem_wr    = STRB_NONE;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_rd    = '0;
    rsp_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (n_err)       state_nxt = ST_RESP;
          else if (req_we) state_nxt = ST_WR;
          else             state_nxt = ST_RD1;
        end
      end
      ST_WR: begin
        // Strobes decode from state so an asynchronous reset kills the write
        // in the same cycle.
        mem_wr    = strb_q;
        state_nxt = ST_RESP;
      end
      ST_RD1: state_nxt = ST_RD2;
      ST_RD2: state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_rd    = we_q ? 5'd0 : rd_q;
`ifdef LSU_MISALIGN_EXC_EN
        rsp_err   = err_q;
`endif
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: bench for load_store_unit with a byte-lane bank model,
// a byte-array reference memory and an in-order expected-response queue.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 6;

  logic              clk;
  logic              nrst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [4:0]        rsp_rd;
  logic              rsp_err;
  logic [2:0]        dbg_state;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_rd     (rsp_rd),
    .rsp_err    (rsp_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bank model (1-cycle read latency) ----------------
  logic [31:0] bank [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (mem_wr[k]) bank[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
    mem_rdata <= bank[mem_addr];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [37:0] exp_q[$];        // {err, rd, rdata}
  int unsigned exp_cyc_q[$];    // cycle count at which the response is due
  logic [7:0]  ref_mem [0:255];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic predict(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         output logic [37:0] e, output int lat);
    logic [1:0]  sz;
    logic [7:0]  a;
    logic        err;
    logic [31:0] v;
    logic [7:0]  b;
    logic [15:0] h;
    sz  = size;
    a   = addr[7:0];
    err = 1'b0;
    v   = '0;
`ifdef LSU_MISALIGN_EXC_EN
    err = (size == 2'b11) || (size == 2'b10 && addr[1:0] != 2'b00) || (size == 2'b01 && addr[0]);
`else
    if (sz == 2'b11) sz = 2'b10;
`endif
    if (sz == 2'b10) a[1:0] = 2'b00;
    if (sz == 2'b01) a[0] = 1'b0;
    if (err) begin
      e   = {1'b1, (we ? 5'd0 : rd), 32'd0};
      lat = 0;
    end else if (we) begin
      case (sz)
        2'b00: ref_mem[a] = wdata[7:0];
        2'b01: begin
          ref_mem[a]       = wdata[7:0];
          ref_mem[a+8'd1]  = wdata[15:8];
        end
        default: begin
          ref_mem[a]       = wdata[7:0];
          ref_mem[a+8'd1]  = wdata[15:8];
          ref_mem[a+8'd2]  = wdata[23:16];
          ref_mem[a+8'd3]  = wdata[31:24];
        end
      endcase
      e   = {1'b0, 5'd0, 32'd0};
      lat = 1;
    end else begin
      case (sz)
        2'b00: begin
          b = ref_mem[a];
          v = sgn ? {{24{b[7]}}, b} : {24'd0, b};
        end
        2'b01: begin
          h = {ref_mem[a+8'd1], ref_mem[a]};
          v = sgn ? {{16{h[15]}}, h} : {16'd0, h};
        end
        default: v = {ref_mem[a+8'd3], ref_mem[a+8'd2], ref_mem[a+8'd1], ref_mem[a]};
      endcase
      e   = {1'b0, rd, v};
      lat = 2;
    end
  endtask

  // Response monitor: sampled on the falling edge.
  always @(negedge clk) begin
    logic [37:0] e;
    int unsigned c;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_rsp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check_val("rsp_rdata", rsp_rdata, e[31:0]);
        check_val("rsp_rd", rsp_rd, e[36:32]);
        check_val("rsp_err", rsp_err, e[37]);
        check_val("rsp_cycle", cyc, c);
        check_val("wr_rsp_overlap", mem_wr, 4'h0);
      end
    end else begin
      check_val("rsp_idle_zero", {rsp_rdata, rsp_rd, rsp_err}, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic hold);
    logic [37:0] e;
    int          lat;
    int          waited;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    req_valid  = 1'b1;
    waited     = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      check_val("accept_timeout", 1, 0);
      req_valid = 1'b0;
      return;
    end
    predict(we, size, sgn, addr, wdata, rd, e, lat);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + lat);
    if (!hold) req_valid = 1'b0;
    check_val("ready_low_after_accept", req_ready, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("drain_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nrst       = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = SZ_BYTE;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_rd     = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    check_val("rst_ready", req_ready, 0);
    check_val("rst_mem_wr", mem_wr, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_state", dbg_state, ST_IDLE);
    nrst = 1'b1;
    @(negedge clk);
    check_val("ready_after_rst", req_ready, 1);

    // Preload words 0..7 so every byte in the test window is defined.
    for (int w = 0; w < 8; w++) issue(1'b1, SZ_WORD, 1'b0, w * 4, $urandom, 5'd0, 1'b0);
    drain();

    // Store word 0xDEADBEEF @0x08
    issue(1'b1, SZ_WORD, 1'b0, 32'h08, 32'hDEADBEEF, 5'd3, 1'b0);
    check_val("sw_mem_addr", mem_addr, 2);
    check_val("sw_mem_wr", mem_wr, 4'b1111);
    check_val("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    drain();

    // Store byte 0xA5 @0x0E, then signed and unsigned byte loads
    issue(1'b1, SZ_BYTE, 1'b0, 32'h0E, 32'h123456A5, 5'd0, 1'b0);
    check_val("sb_mem_wr", mem_wr, 4'b0100);
    check_val("sb_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    drain();
    issue(1'b0, SZ_BYTE, 1'b1, 32'h0E, 32'h0, 5'd7, 1'b0);
    check_val("lb_no_write", mem_wr, 0);
    drain();
    issue(1'b0, SZ_BYTE, 1'b0, 32'h0E, 32'h0, 5'd7, 1'b0);
    drain();

    // Half loads from bank word 0x80017FFF
    issue(1'b1, SZ_WORD, 1'b0, 32'h08, 32'h80017FFF, 5'd0, 1'b0);
    drain();
    issue(1'b0, SZ_HALF, 1'b1, 32'h0A, 32'h0, 5'd2, 1'b0);
    drain();
    issue(1'b0, SZ_HALF, 1'b1, 32'h08, 32'h0, 5'd3, 1'b0);
    drain();
    issue(1'b0, SZ_HALF, 1'b0, 32'h0A, 32'h0, 5'd4, 1'b0);
    drain();

    // Half and byte store steering
    issue(1'b1, SZ_HALF, 1'b0, 32'h12, 32'hFFFF1234, 5'd0, 1'b0);
    check_val("sh_mem_wr", mem_wr, 4'b1100);
    check_val("sh_mem_wdata", mem_wdata, 32'h12341234);
    check_val("sh_mem_addr", mem_addr, 4);
    drain();
    issue(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h0000003C, 5'd0, 1'b0);
    check_val("sb1_mem_wr", mem_wr, 4'b0010);
    drain();
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 5'd5, 1'b0);
    drain();

    // Misaligned / invalid-size requests
    issue(1'b1, SZ_WORD, 1'b0, 32'h00, 32'h11223344, 5'd0, 1'b0);
    drain();
    issue(1'b0, SZ_WORD, 1'b0, 32'h02, 32'h0, 5'd6, 1'b0);
    check_val("mis_lw_no_write", mem_wr, 0);
    drain();
    issue(1'b1, SZ_WORD, 1'b0, 32'h05, 32'h55667788, 5'd0, 1'b0);
    drain();
    issue(1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0, 5'd8, 1'b0);
    drain();
    issue(1'b0, SZ_BAD, 1'b0, 32'h00, 32'h0, 5'd9, 1'b0);
    drain();
    issue(1'b1, SZ_HALF, 1'b0, 32'h13, 32'h0000ABCD, 5'd0, 1'b0);
    drain();
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 5'd10, 1'b0);
    drain();

    // Reset while a store sits in WR: the write must vanish.
    req_we    = 1'b1;
    req_size  = SZ_WORD;
    req_addr  = 32'h1C;
    req_wdata = 32'hCAFEF00D;
    req_rd    = 5'd0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_val("abort_wr_active", mem_wr, 4'b1111);
    nrst = 1'b0;
    #1;
    check_val("abort_mem_wr", mem_wr, 0);
    check_val("abort_ready", req_ready, 0);
    check_val("abort_rsp_valid", rsp_valid, 0);
    check_val("abort_mem_addr", mem_addr, 0);
    check_val("abort_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    check_val("abort_ready_release", req_ready, 1);
    repeat (4) @(negedge clk);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1C, 32'h0, 5'd11, 1'b0);
    drain();

    // Back-to-back with req_valid held high
    issue(1'b1, SZ_BYTE, 1'b0, 32'h15, 32'h0000005A, 5'd0, 1'b1);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h15, 32'h0, 5'd12, 1'b1);
    issue(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, 5'd13, 1'b0);
    drain();

    // Random mix in the preloaded window
    for (int i = 0; i < 24; i++) begin
      issue(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
            32'($urandom_range(31, 0)), $urandom, 5'($urandom_range(31, 1)),
            (i == 23) ? 1'b0 : 1'($urandom_range(1, 0)));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
